// File: rtl/instr_issue_if.sv
// ---------------------------------------------------------------------------
// instr_issue_if
// Word stream from the program source into the instruction issue unit.
//   in_data  : instruction or immediate word
//   in_valid : in_data is valid this cycle
//   in_ready : issue unit accepts a word this cycle
// A word transfers on a rising edge where in_valid and in_ready are both 1.
// Modports: master = program source, slave = instr_issue.
// ---------------------------------------------------------------------------
interface instr_issue_if;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/instr_issue.sv
// ---------------------------------------------------------------------------
// instr_issue
// Buffers 16-bit instruction/immediate words in a small FIFO, decodes the
// word at the head and issues it to the control FSM as a run strobe (w)
// with func/rx/ry (and data_out for loads) held for the execute length.
//
// Ports:
//   clk        : single clock, all state changes on the rising edge
//   reset      : synchronous, active-high
//   in_if      : slave side of instr_issue_if (in_data/in_valid/in_ready)
//   w          : run strobe, high for every EXEC cycle
//   func       : opcode (000 load, 001 move, 010 add, 011 xor)
//   rx, ry     : register indices
//   data_out   : immediate of the last load
//   done       : one-cycle pulse on the last EXEC cycle
//   busy       : high while not IDLE
//   err        : illegal-instruction indication
//   fifo_count : current FIFO occupancy
//
// Optional build macro ILLEGAL_TRAP_EN: an illegal head is not popped, err
// becomes sticky and issue halts until reset. Without it an illegal head is
// dropped with a one-cycle err pulse.
// ---------------------------------------------------------------------------
module instr_issue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    instr_issue_if.slave             in_if,
    output logic                     w,
    output logic [2:0]               func,
    output logic [4:0]               rx,
    output logic [4:0]               ry,
    output logic [15:0]              data_out,
    output logic                     done,
    output logic                     busy,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, EXEC} state_t;

    logic [15:0]   mem_q [DEPTH];
    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    step_q, step_d;
    logic          w_q, w_d;
    logic [2:0]    func_q, func_d;
    logic [4:0]    rx_q, rx_d;
    logic [4:0]    ry_q, ry_d;
    logic [15:0]   data_out_q, data_out_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    logic          push;
    logic [1:0]    pop_n;
    logic          halt;
    logic [AW-1:0] rd_next;
    logic [2:0]    head_func;
    logic [4:0]    head_rx;
    logic [4:0]    head_ry;
    logic          head_legal;

    // Readiness looks only at the registered count, so a full FIFO refuses
    // a push even in a cycle where it also pops.
    assign in_if.in_ready = !reset && (count_q < (AW+1)'(DEPTH));
    assign push           = in_if.in_valid && in_if.in_ready;

    assign rd_next    = rd_ptr_q + AW'(1);
    assign head_func  = mem_q[rd_ptr_q][15:13];
    assign head_rx    = mem_q[rd_ptr_q][12:8];
    assign head_ry    = mem_q[rd_ptr_q][7:3];
    assign head_legal = !head_func[2] && !head_rx[4] && !head_ry[4];

`ifdef ILLEGAL_TRAP_EN
    assign halt = err_q;
`else
    assign halt = 1'b0;
`endif

    // Issue FSM next-state: decode the head in IDLE, count down in EXEC.
    // step holds the EXEC cycles remaining after the current one, and done
    // is precomputed so that it lands on the last EXEC cycle.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        w_d        = w_q;
        func_d     = func_q;
        rx_d       = rx_q;
        ry_d       = ry_q;
        data_out_d = data_out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        err_d      = err_q;
`else
        err_d      = 1'b0;
`endif
        pop_n      = 2'd0;

        case (state_q)
            IDLE: begin
                if (count_q != '0 && !halt) begin
                    if (!head_legal) begin
`ifdef ILLEGAL_TRAP_EN
                        err_d = 1'b1;
`else
                        pop_n = 2'd1;
                        err_d = 1'b1;
`endif
                    end else if (head_func == 3'b000) begin
                        // A load needs its immediate already in the FIFO.
                        if (count_q >= (AW+1)'(2)) begin
                            pop_n      = 2'd2;
                            func_d     = head_func;
                            rx_d       = head_rx;
                            ry_d       = head_ry;
                            data_out_d = mem_q[rd_next];
                            state_d    = EXEC;
                            w_d        = 1'b1;
                            busy_d     = 1'b1;
                            step_d     = 2'd0;
                            done_d     = 1'b1;
                        end
                    end else begin
                        pop_n   = 2'd1;
                        func_d  = head_func;
                        rx_d    = head_rx;
                        ry_d    = head_ry;
                        state_d = EXEC;
                        w_d     = 1'b1;
                        busy_d  = 1'b1;
                        if (head_func[1]) begin
                            step_d = 2'd2;
                            done_d = 1'b0;
                        end else begin
                            step_d = 2'd0;
                            done_d = 1'b1;
                        end
                    end
                end
            end
            EXEC: begin
                if (step_q == 2'd0) begin
                    state_d = IDLE;
                    w_d     = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    step_d = step_q - 2'd1;
                    done_d = (step_q == 2'd1);
                end
            end
            default: begin
                state_d = IDLE;
                w_d     = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop_n);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop_n);
    end

    // All control state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            step_q     <= 2'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            w_q        <= 1'b0;
            func_q     <= 3'd0;
            rx_q       <= 5'd0;
            ry_q       <= 5'd0;
            data_out_q <= 16'd0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            w_q        <= w_d;
            func_q     <= func_d;
            rx_q       <= rx_d;
            ry_q       <= ry_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    // FIFO storage; contents need no reset since pointers and count do.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_if.in_data;
        end
    end

    assign w          = w_q;
    assign func       = func_q;
    assign rx         = rx_q;
    assign ry         = ry_q;
    assign data_out   = data_out_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_instr_issue.sv
// ---------------------------------------------------------------------------
// tb_instr_issue
// Self-checking bench for instr_issue (DEPTH = 4). Expected issues are queued
// when words are driven; a negedge monitor pops and compares them whenever
// the DUT raises w (or pulses err for an illegal word in the default build).
// ---------------------------------------------------------------------------
module tb_instr_issue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] imm;
        bit          isLoad;
        bit          illegal;
        logic [2:0]  func;
        logic [4:0]  rx;
        logic [4:0]  ry;
        logic [15:0] dataOut;
        int          len;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        w;
    logic [2:0]  func;
    logic [4:0]  rx;
    logic [4:0]  ry;
    logic [15:0] data_out;
    logic        done;
    logic        busy;
    logic        err;
    logic [2:0]  fifo_count;

    instr_issue_if inIf ();

    instr_issue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_if      (inIf),
        .w          (w),
        .func       (func),
        .rx         (rx),
        .ry         (ry),
        .data_out   (data_out),
        .done       (done),
        .busy       (busy),
        .err        (err),
        .fifo_count (fifo_count)
    );

    int   testsRun    = 0;
    int   testsFailed = 0;
    vec_t expQ[$];
    bit   sawFull;

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges despite the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic vec_t makeVec(input logic [15:0] instr, input logic [15:0] imm, input bit isLoad,
                                     input bit illegal, input logic [2:0] f, input logic [4:0] x,
                                     input logic [4:0] y, input logic [15:0] d, input int len);
        vec_t v;
        v.instr = instr; v.imm = imm; v.isLoad = isLoad; v.illegal = illegal;
        v.func = f; v.rx = x; v.ry = y; v.dataOut = d; v.len = len;
        return v;
    endfunction

    // Drive one word and hold it until accepted; checks in_ready is low
    // whenever the FIFO is seen full before an edge.
    task automatic pushWord(input logic [15:0] word);
        int budget;
        budget = 0;
        inIf.in_valid = 1'b1;
        inIf.in_data  = word;
        #1;
        while (!inIf.in_ready && budget < 100) begin
            if (fifo_count == 3'(DEPTH)) begin
                sawFull = 1'b1;
                checkOutput("in_ready_full", inIf.in_ready, 0);
            end
            @(posedge clk); #1;
            budget++;
        end
        checkOutput("push_accept_timeout", (budget < 100), 1);
        @(posedge clk); #1;
        inIf.in_valid = 1'b0;
    endtask

    // Queue the expected issue (or err) for a vector and drive its words.
    task automatic applyStimulus(input vec_t v);
`ifdef ILLEGAL_TRAP_EN
        if (!v.illegal) expQ.push_back(v);
`else
        expQ.push_back(v);
`endif
        pushWord(v.instr);
        if (v.isLoad) pushWord(v.imm);
    endtask

    task automatic waitDrain();
        bit drained;
        drained = 1'b0;
        for (int i = 0; i < 300 && !drained; i++) begin
            @(negedge clk);
            if (expQ.size() == 0 && !busy && !w && fifo_count == 3'd0) drained = 1'b1;
        end
        checkOutput("drain", drained, 1);
    endtask

    task automatic waitW(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (w) seen = 1'b1;
        end
        checkOutput("wait_w_timeout", seen, 1);
    endtask

    // Scoreboard monitor: on each rising w pop an expected issue and check
    // the decoded fields, then check run length and done placement.
    vec_t cur;
    bit   runActive = 1'b0;
    int   runLen    = 0;
    always @(negedge clk) begin
        if (reset) begin
            runActive = 1'b0;
            runLen    = 0;
        end else begin
            if (w && !runActive) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_issue", 1, 0);
                    cur = makeVec(0, 0, 0, 0, 0, 0, 0, 0, 1);
                end else begin
                    cur = expQ.pop_front();
                    checkOutput("issue_legal", cur.illegal, 0);
                    checkOutput("issue_func", func, cur.func);
                    checkOutput("issue_rx", rx, cur.rx);
                    checkOutput("issue_ry", ry, cur.ry);
                    if (cur.isLoad) checkOutput("issue_data_out", data_out, cur.dataOut);
                end
                runActive = 1'b1;
                runLen    = 0;
            end
            if (w) begin
                runLen++;
                checkOutput("done_position", done, (runLen == cur.len));
                checkOutput("func_stable", func, cur.func);
            end else begin
                checkOutput("done_w_low", done, 0);
                if (runActive) begin
                    checkOutput("w_run_length", runLen, cur.len);
                    runActive = 1'b0;
                end
            end
`ifndef ILLEGAL_TRAP_EN
            if (err) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_err", 1, 0);
                end else begin
                    cur = expQ.pop_front();
                    checkOutput("err_expected", cur.illegal, 1);
                end
            end
`endif
        end
    end

    vec_t vecs[8];
    logic [7:0] wPattern;
    int errCount;

    initial begin
        vecs[0] = makeVec(16'h2A08, 16'h0000, 0, 0, 3'd1, 5'd10, 5'd1,  16'h0000, 1);
        vecs[1] = makeVec(16'h0F78, 16'hFFFF, 1, 0, 3'd0, 5'd15, 5'd15, 16'hFFFF, 1);
        vecs[2] = makeVec(16'h4110, 16'h0000, 0, 0, 3'd2, 5'd1,  5'd2,  16'h0000, 3);
        vecs[3] = makeVec(16'h3000, 16'h0000, 0, 1, 3'd1, 5'd16, 5'd0,  16'h0000, 0);
        vecs[4] = makeVec(16'h6F78, 16'h0000, 0, 0, 3'd3, 5'd15, 5'd15, 16'h0000, 3);
        vecs[5] = makeVec(16'h2080, 16'h0000, 0, 1, 3'd1, 5'd0,  5'd16, 16'h0000, 0);
        vecs[6] = makeVec(16'hE000, 16'h0000, 0, 1, 3'd7, 5'd0,  5'd0,  16'h0000, 0);
        vecs[7] = makeVec(16'h2F78, 16'h0000, 0, 0, 3'd1, 5'd15, 5'd15, 16'h0000, 1);

        sawFull       = 1'b0;
        reset         = 1'b1;
        inIf.in_valid = 1'b0;
        inIf.in_data  = 16'h0000;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", inIf.in_ready, 0);
        checkOutput("reset_w", w, 0);
        checkOutput("reset_func", func, 0);
        checkOutput("reset_rx", rx, 0);
        checkOutput("reset_ry", ry, 0);
        checkOutput("reset_data_out", data_out, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_count", fifo_count, 0);
        reset = 1'b0;
        #1;
        checkOutput("post_reset_in_ready", inIf.in_ready, 1);

        // Single move.
        applyStimulus(vecs[0]);
        waitDrain();

        // Load whose immediate arrives late must stall without popping.
        expQ.push_back(makeVec(16'h0400, 16'h1234, 1, 0, 3'd0, 5'd4, 5'd0, 16'h1234, 1));
        pushWord(16'h0400);
        repeat (5) begin
            @(posedge clk); #1;
            checkOutput("load_stall_w", w, 0);
            checkOutput("load_stall_count", fifo_count, 1);
        end
        pushWord(16'h1234);
        waitDrain();

        // Back-to-back add then xor: 3 high, 1 low, 3 high.
        applyStimulus(vecs[2]);
        applyStimulus(makeVec(16'h6110, 16'h0000, 0, 0, 3'd3, 5'd1, 5'd2, 16'h0000, 3));
        begin
            bit seen;
            waitW(seen);
            wPattern[7] = w;
            for (int i = 6; i >= 0; i--) begin
                @(negedge clk);
                wPattern[i] = w;
            end
            checkOutput("add_xor_w_pattern", wPattern, 8'b11101110);
        end
        waitDrain();

        // Table of mixed vectors fed back to back.
        for (int i = 0; i < 8; i++) begin
`ifdef ILLEGAL_TRAP_EN
            if (!vecs[i].illegal) applyStimulus(vecs[i]);
`else
            applyStimulus(vecs[i]);
`endif
        end
        waitDrain();

        // Saturate the FIFO with six distinct adds under continuous valid.
        sawFull = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(makeVec(16'h4010 | (16'(i + 1) << 8), 16'h0000, 0, 0, 3'd2,
                                  5'(i + 1), 5'd2, 16'h0000, 3));
        end
        checkOutput("fifo_reached_full", sawFull, 1);
        waitDrain();

        // Reset on the second EXEC cycle of an add aborts it.
        applyStimulus(vecs[2]);
        begin
            bit seen;
            waitW(seen);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checkOutput("abort_in_ready", inIf.in_ready, 0);
        @(posedge clk); #1;
        checkOutput("abort_w", w, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_count", fifo_count, 0);
        checkOutput("abort_busy", busy, 0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("abort_idle_busy", busy, 0);

`ifdef ILLEGAL_TRAP_EN
        // Illegal head traps: sticky err, word kept, later words not issued.
        pushWord(16'h8000);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("trap_err", err, 1);
        checkOutput("trap_count", fifo_count, 1);
        pushWord(16'h2A08);
        repeat (8) begin
            @(posedge clk); #1;
            checkOutput("trap_no_issue", w, 0);
        end
        checkOutput("trap_err_sticky", err, 1);
        checkOutput("trap_count2", fifo_count, 2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("trap_reset_err", err, 0);
`else
        // Illegal head: one-cycle err pulse and the word is dropped.
        expQ.push_back(makeVec(16'h8000, 16'h0000, 0, 1, 3'd4, 5'd0, 5'd0, 16'h0000, 0));
        pushWord(16'h8000);
        errCount = 0;
        repeat (6) begin
            @(negedge clk);
            if (err) errCount++;
        end
        checkOutput("illegal_err_cycles", errCount, 1);
        checkOutput("illegal_count", fifo_count, 0);
        checkOutput("illegal_w", w, 0);
`endif

        checkOutput("scoreboard_empty", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
